comp_pointer_bank: RTL and testbench

Parametrised circular-buffer pointer bank for the fingerprint comparator, successor to the fixed three-core pointer register block. Holds start/end/head/tail pointers per (task, logical core) for NUM_CORES redundant cores. Adds full/empty detection, refusal of overflowing/underflowing increments with sticky per-task error status, and single-winner fixed-priority arbitration between the CSR, fingerprint and comparator request channels.

---
 rtl/comp_pointer_bank.sv | 140 ++++++++++++++
 tb/tb_comp_pointer_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/comp_pointer_bank.sv
// comp_pointer_bank: per-(task, core) circular-buffer pointers with full/empty detection,
// sticky per-task error status and fixed-priority arbitration of csr/head/tail/reset channels.
module comp_pointer_bank #(
    parameter int NUM_TASKS  = 16,
    parameter int KEY_WIDTH  = 4,
    parameter int NUM_CORES  = 3,
    parameter int CORE_WIDTH = 2,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                            clk,
    input  logic                            comp_reset_task_ack,
    input  logic [CORE_WIDTH-1:0]           csr_core_id,
    input  logic [KEY_WIDTH-1:0]            csr_task_id,
    input  logic                            csr_start_write,
    input  logic                            csr_end_write,
    input  logic [ADDR_WIDTH-1:0]           csr_pointer_data,
    output logic                            csr_ack,
    input  logic [CORE_WIDTH-1:0]           fprint_core_id,
    input  logic [KEY_WIDTH-1:0]            fprint_task_id,
    input  logic                            fprint_inc_head,
    output logic                            fprint_inc_head_ack,
    output logic [ADDR_WIDTH-1:0]           fprint_head_pointer,
    output logic                            fprint_full,
    input  logic [KEY_WIDTH-1:0]            cmp_task_id,
    input  logic                            cmp_inc_tail,
    output logic                            cmp_inc_tail_ack,
    input  logic                            cmp_task_reset,
    output logic                            cmp_task_reset_ack,
    output logic [NUM_CORES*ADDR_WIDTH-1:0] cmp_tail_pointer,
    output logic [NUM_CORES-1:0]            cmp_empty,
    output logic [NUM_TASKS-1:0]            err_status
);
    typedef enum logic {IDLE, DONE} state_t;
    localparam logic [CORE_WIDTH:0] NC = (CORE_WIDTH+1)'(NUM_CORES);

    logic [ADDR_WIDTH-1:0] r_start [NUM_CORES][NUM_TASKS];
    logic [ADDR_WIDTH-1:0] r_end   [NUM_CORES][NUM_TASKS];
    logic [ADDR_WIDTH-1:0] r_head  [NUM_CORES][NUM_TASKS];
    logic [ADDR_WIDTH-1:0] r_tail  [NUM_CORES][NUM_TASKS];
    state_t r_st_csr, r_st_head, r_st_tail, r_st_rst;

    logic                  w_csr_req, w_go_rst, w_go_csr, w_go_tail, w_go_head;
    logic                  w_csr_ok, w_fp_ok, w_head_full, w_any_empty;
    logic [CORE_WIDTH-1:0] w_csr_c, w_fp_c;

    function automatic logic [ADDR_WIDTH-1:0] nxt(input logic [ADDR_WIDTH-1:0] p, s, e);
        return (p == e) ? s : p + ADDR_WIDTH'(1);
    endfunction

    assign w_csr_req = csr_start_write | csr_end_write;
    assign w_go_rst  = (r_st_rst == IDLE) && cmp_task_reset;
    assign w_go_csr  = (r_st_csr == IDLE) && w_csr_req && !w_go_rst;
    assign w_go_tail = (r_st_tail == IDLE) && cmp_inc_tail && !w_go_rst && !w_go_csr;
    assign w_go_head = (r_st_head == IDLE) && fprint_inc_head && !w_go_rst && !w_go_csr && !w_go_tail;
    assign w_csr_ok  = {1'b0, csr_core_id} < NC;
    assign w_fp_ok   = {1'b0, fprint_core_id} < NC;
    // Out-of-range cores are steered to core 0 for lookup only; updates stay gated by *_ok.
    assign w_csr_c   = w_csr_ok ? csr_core_id : '0;
    assign w_fp_c    = w_fp_ok ? fprint_core_id : '0;
    assign w_head_full = nxt(r_head[w_fp_c][fprint_task_id], r_start[w_fp_c][fprint_task_id],
                             r_end[w_fp_c][fprint_task_id]) == r_tail[w_fp_c][fprint_task_id];

    always_comb begin
        w_any_empty = 1'b0;
        for (int c = 0; c < NUM_CORES; c++)
            w_any_empty |= r_head[c][cmp_task_id] == r_tail[c][cmp_task_id];
    end

    always_ff @(posedge clk or posedge comp_reset_task_ack) begin
        if (comp_reset_task_ack) begin
            for (int c = 0; c < NUM_CORES; c++)
                for (int t = 0; t < NUM_TASKS; t++) begin
                    r_start[c][t] <= '0;
                    r_end[c][t]   <= '0;
                    r_head[c][t]  <= '0;
                    r_tail[c][t]  <= '0;
                end
            r_st_csr            <= IDLE;
            r_st_head           <= IDLE;
            r_st_tail           <= IDLE;
            r_st_rst            <= IDLE;
            csr_ack             <= 1'b0;
            fprint_inc_head_ack <= 1'b0;
            cmp_inc_tail_ack    <= 1'b0;
            cmp_task_reset_ack  <= 1'b0;
            fprint_head_pointer <= '0;
            fprint_full         <= 1'b0;
            cmp_tail_pointer    <= '0;
            cmp_empty           <= '0;
            err_status          <= '0;
        end else begin
            r_st_rst            <= w_go_rst ? DONE : cmp_task_reset ? r_st_rst : IDLE;
            r_st_csr            <= w_go_csr ? DONE : w_csr_req ? r_st_csr : IDLE;
            r_st_tail           <= w_go_tail ? DONE : cmp_inc_tail ? r_st_tail : IDLE;
            r_st_head           <= w_go_head ? DONE : fprint_inc_head ? r_st_head : IDLE;
            cmp_task_reset_ack  <= w_go_rst;
            csr_ack             <= w_go_csr;
            cmp_inc_tail_ack    <= w_go_tail;
            fprint_inc_head_ack <= w_go_head;
            if (w_go_rst) begin
                for (int c = 0; c < NUM_CORES; c++) begin
                    r_head[c][cmp_task_id] <= r_start[c][cmp_task_id];
                    r_tail[c][cmp_task_id] <= r_start[c][cmp_task_id];
                end
                err_status[cmp_task_id] <= 1'b0;
            end
            if (w_go_csr && w_csr_ok) begin
                if (csr_start_write) begin
                    r_start[w_csr_c][csr_task_id] <= csr_pointer_data;
                    r_head[w_csr_c][csr_task_id]  <= csr_pointer_data;
                    r_tail[w_csr_c][csr_task_id]  <= csr_pointer_data;
                    err_status[csr_task_id]       <= 1'b0;
                end else
                    r_end[w_csr_c][csr_task_id] <= csr_pointer_data;
            end
            if (w_go_tail) begin
                if (w_any_empty)
                    err_status[cmp_task_id] <= 1'b1;
                else
                    for (int c = 0; c < NUM_CORES; c++)
                        r_tail[c][cmp_task_id] <= nxt(r_tail[c][cmp_task_id],
                                                      r_start[c][cmp_task_id], r_end[c][cmp_task_id]);
            end
            if (w_go_head && w_fp_ok) begin
                if (w_head_full)
                    err_status[fprint_task_id] <= 1'b1;
                else
                    r_head[w_fp_c][fprint_task_id] <= nxt(r_head[w_fp_c][fprint_task_id],
                                                          r_start[w_fp_c][fprint_task_id],
                                                          r_end[w_fp_c][fprint_task_id]);
            end
            fprint_head_pointer <= w_fp_ok ? r_head[w_fp_c][fprint_task_id] : '0;
            fprint_full         <= w_fp_ok & w_head_full;
            for (int c = 0; c < NUM_CORES; c++) begin
                cmp_tail_pointer[c*ADDR_WIDTH +: ADDR_WIDTH] <= r_tail[c][cmp_task_id];
                cmp_empty[c] <= r_head[c][cmp_task_id] == r_tail[c][cmp_task_id];
            end
        end
    end
endmodule

// File: tb/tb_comp_pointer_bank.sv
// tb_comp_pointer_bank: directed handshake sequences with hand-computed pointer expectations.
module tb_comp_pointer_bank;
    logic        clk = 1'b0;
    logic        comp_reset_task_ack = 1'b1;
    logic [1:0]  csr_core_id = '0;
    logic [3:0]  csr_task_id = '0;
    logic        csr_start_write = 1'b0;
    logic        csr_end_write = 1'b0;
    logic [9:0]  csr_pointer_data = '0;
    logic        csr_ack;
    logic [1:0]  fprint_core_id = '0;
    logic [3:0]  fprint_task_id = '0;
    logic        fprint_inc_head = 1'b0;
    logic        fprint_inc_head_ack;
    logic [9:0]  fprint_head_pointer;
    logic        fprint_full;
    logic [3:0]  cmp_task_id = '0;
    logic        cmp_inc_tail = 1'b0;
    logic        cmp_inc_tail_ack;
    logic        cmp_task_reset = 1'b0;
    logic        cmp_task_reset_ack;
    logic [29:0] cmp_tail_pointer;
    logic [2:0]  cmp_empty;
    logic [15:0] err_status;

    int checks = 0;
    int failures = 0;

    comp_pointer_bank dut (
        .clk(clk), .comp_reset_task_ack(comp_reset_task_ack),
        .csr_core_id(csr_core_id), .csr_task_id(csr_task_id),
        .csr_start_write(csr_start_write), .csr_end_write(csr_end_write),
        .csr_pointer_data(csr_pointer_data), .csr_ack(csr_ack),
        .fprint_core_id(fprint_core_id), .fprint_task_id(fprint_task_id),
        .fprint_inc_head(fprint_inc_head), .fprint_inc_head_ack(fprint_inc_head_ack),
        .fprint_head_pointer(fprint_head_pointer), .fprint_full(fprint_full),
        .cmp_task_id(cmp_task_id), .cmp_inc_tail(cmp_inc_tail), .cmp_inc_tail_ack(cmp_inc_tail_ack),
        .cmp_task_reset(cmp_task_reset), .cmp_task_reset_ack(cmp_task_reset_ack),
        .cmp_tail_pointer(cmp_tail_pointer), .cmp_empty(cmp_empty), .err_status(err_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(input int ch);
        return ch == 0 ? csr_ack : ch == 1 ? fprint_inc_head_ack : ch == 2 ? cmp_inc_tail_ack : cmp_task_reset_ack;
    endfunction

    task automatic drop(input int ch);
        case (ch)
            0: begin csr_start_write = 1'b0; csr_end_write = 1'b0; end
            1: fprint_inc_head = 1'b0;
            2: cmp_inc_tail = 1'b0;
            default: cmp_task_reset = 1'b0;
        endcase
    endtask

    task automatic handshake(input int ch, input string tag);
        int n = 0;
        logic a;
        do begin
            @(negedge clk);
            n++;
            a = ack_of(ch);
        end while (!a && n < 20);
        chk({tag, " ack"}, a, 1);
        drop(ch);
        @(negedge clk);
        chk({tag, " ack pulse"}, ack_of(ch), 0);
    endtask

    task automatic csr(input logic [1:0] c, input logic [3:0] t, input logic is_start, input logic [9:0] d);
        csr_core_id = c; csr_task_id = t; csr_pointer_data = d;
        csr_start_write = is_start; csr_end_write = !is_start;
        handshake(0, "csr");
    endtask

    task automatic hinc(input logic [1:0] c, input logic [3:0] t);
        fprint_core_id = c; fprint_task_id = t; fprint_inc_head = 1'b1;
        handshake(1, "head");
    endtask

    task automatic tinc(input logic [3:0] t);
        cmp_task_id = t; cmp_inc_tail = 1'b1;
        handshake(2, "tail");
    endtask

    task automatic trst(input logic [3:0] t);
        cmp_task_id = t; cmp_task_reset = 1'b1;
        handshake(3, "treset");
    endtask

    task automatic sel_fp(input logic [1:0] c, input logic [3:0] t);
        fprint_core_id = c; fprint_task_id = t;
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst err", err_status, 0);
        chk("rst acks", {csr_ack, fprint_inc_head_ack, cmp_inc_tail_ack, cmp_task_reset_ack}, 0);
        chk("rst head", fprint_head_pointer, 0);
        chk("rst full", fprint_full, 0);
        chk("rst tails", cmp_tail_pointer, 0);
        chk("rst empty", cmp_empty, 0);
        comp_reset_task_ack = 1'b0;

        fprint_core_id = 1; fprint_task_id = 2; cmp_task_id = 2;
        csr(1, 2, 1, 70);
        csr(1, 2, 0, 79);
        chk("t2c1 head", fprint_head_pointer, 70);
        chk("t2c1 full", fprint_full, 0);
        chk("t2c1 empty", cmp_empty[1], 1);
        chk("t2c1 tail", cmp_tail_pointer[19:10], 70);

        csr(0, 2, 1, 60); csr(0, 2, 0, 69);
        csr(2, 2, 1, 80); csr(2, 2, 0, 89);
        for (int i = 0; i < 9; i++) hinc(0, 2);
        chk("c0 head 69", fprint_head_pointer, 69);
        chk("c0 full", fprint_full, 1);
        chk("err clear", err_status, 16'h0000);
        hinc(0, 2);
        chk("c0 overflow head", fprint_head_pointer, 69);
        chk("c0 overflow err", err_status, 16'h0004);

        for (int i = 0; i < 9; i++) hinc(1, 2);
        chk("c1 head 79", fprint_head_pointer, 79);
        for (int i = 0; i < 9; i++) hinc(2, 2);
        chk("c2 head 89", fprint_head_pointer, 89);
        for (int i = 0; i < 9; i++) tinc(2);
        chk("tails end", cmp_tail_pointer, {10'd89, 10'd79, 10'd69});
        chk("empty all", cmp_empty, 3'b111);
        chk("err sticky", err_status, 16'h0004);
        hinc(0, 2);
        chk("c0 head wrap", fprint_head_pointer, 60);
        chk("c0 not full", fprint_full, 0);
        hinc(1, 2);
        chk("c1 head wrap", fprint_head_pointer, 70);
        hinc(2, 2);
        chk("c2 head wrap", fprint_head_pointer, 80);
        tinc(2);
        chk("tails wrap", cmp_tail_pointer, {10'd80, 10'd70, 10'd60});
        chk("empty after wrap", cmp_empty, 3'b111);

        for (int c = 0; c < 3; c++) begin
            csr(2'(c), 5, 1, 0);
            csr(2'(c), 5, 0, 9);
        end
        tinc(5);
        chk("t5 tails stay", cmp_tail_pointer, 0);
        chk("t5 empty", cmp_empty, 3'b111);
        chk("t5 underflow err", err_status, 16'h0024);
        trst(5);
        chk("t5 reset err", err_status, 16'h0004);

        hinc(1, 2);
        chk("c1 head 71", fprint_head_pointer, 71);
        fprint_core_id = 0; fprint_task_id = 2; cmp_task_id = 2;
        cmp_task_reset = 1'b1; fprint_inc_head = 1'b1;
        @(negedge clk);
        chk("arb reset ack", cmp_task_reset_ack, 1);
        chk("arb head waits", fprint_inc_head_ack, 0);
        cmp_task_reset = 1'b0;
        @(negedge clk);
        chk("arb reset pulse", cmp_task_reset_ack, 0);
        chk("arb head ack", fprint_inc_head_ack, 1);
        fprint_inc_head = 1'b0;
        @(negedge clk);
        chk("arb head pulse", fprint_inc_head_ack, 0);
        chk("arb head start+1", fprint_head_pointer, 61);
        chk("arb err cleared", err_status, 16'h0000);
        chk("arb empty", cmp_empty, 3'b110);
        sel_fp(1, 2);
        chk("arb c1 reset", fprint_head_pointer, 70);

        csr(3, 2, 1, 5);
        hinc(3, 2);
        sel_fp(0, 2);
        chk("bad core head", fprint_head_pointer, 61);
        chk("bad core err", err_status, 16'h0000);

        fprint_inc_head = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!fprint_inc_head_ack && n < 20);
        chk("pre-reset ack", fprint_inc_head_ack, 1);
        @(negedge clk);
        chk("done ack low", fprint_inc_head_ack, 0);
        comp_reset_task_ack = 1'b1;
        #1;
        chk("async head", fprint_head_pointer, 0);
        chk("async tails", cmp_tail_pointer, 0);
        chk("async empty", cmp_empty, 0);
        @(negedge clk);
        comp_reset_task_ack = 1'b0;
        handshake(1, "post-reset head");
        chk("post-reset err", err_status, 16'h0004);
        chk("post-reset full", fprint_full, 1);
        chk("post-reset head", fprint_head_pointer, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
